// File: rtl/uc_pkg.sv
// uc_pkg: shared types and constants for the in-flight write scoreboard.
//   REG_ADDR_W  register address width
//   REG_ZERO    hardwired-zero register address
//   MAX_LAT_W   storage width of a slot countdown (covers any LAT_W up to 8)
//   sb_entry_t  one tracker slot: valid flag, destination, remaining cycles
//   eff_latency maps a requested latency of 0 to 1
package uc_pkg;

    localparam int REG_ADDR_W = 6;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 6'd0;
    localparam int MAX_LAT_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic [MAX_LAT_W-1:0]  remaining;
    } sb_entry_t;

    function automatic logic [MAX_LAT_W-1:0] eff_latency(input logic [MAX_LAT_W-1:0] lat);
        return (lat == '0) ? MAX_LAT_W'(1) : lat;
    endfunction

endpackage

// File: rtl/uc_scoreboard_if.sv
// uc_scoreboard_if: issue handshake between the operand-read stage and the
// scoreboard.
//   master : operand stage (drives the instruction, sees issue_ready/hold)
//   slave  : scoreboard (samples the instruction, drives issue_ready/hold)
interface uc_scoreboard_if #(
    parameter int LAT_W = 3
) ();
    import uc_pkg::*;

    logic                  issue_valid;
    logic                  read_a_en;
    logic                  read_b_en;
    logic [REG_ADDR_W-1:0] operand_a;
    logic [REG_ADDR_W-1:0] operand_b;
    logic                  write_en;
    logic [REG_ADDR_W-1:0] dest_c;
    logic [LAT_W-1:0]      latency;
    logic                  issue_ready;
    logic                  hold_registers;

    modport master (
        output issue_valid, read_a_en, read_b_en, operand_a, operand_b,
               write_en, dest_c, latency,
        input  issue_ready, hold_registers
    );

    modport slave (
        input  issue_valid, read_a_en, read_b_en, operand_a, operand_b,
               write_en, dest_c, latency,
        output issue_ready, hold_registers
    );

endinterface

// File: rtl/uc_sb_slot.sv
// uc_sb_slot: one in-flight write tracker slot with its countdown.
//   clk, rst_n      clock, async active-low reset
//   flush           discard the entry on the next edge
//   load            allocate this slot (wins over a same-cycle retire)
//   load_dest/lat   destination and latency for the allocation
//   rd_a/rd_b/wr    addresses to compare, each with a check enable
//   match_*         address hits a valid, non-retiring entry
//   retiring        valid and one cycle remaining
//   valid           slot occupied
module uc_sb_slot
    import uc_pkg::*;
#(
    parameter int LAT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  load,
    input  logic [REG_ADDR_W-1:0] load_dest,
    input  logic [LAT_W-1:0]      load_lat,
    input  logic                  rd_a_chk,
    input  logic [REG_ADDR_W-1:0] rd_a,
    input  logic                  rd_b_chk,
    input  logic [REG_ADDR_W-1:0] rd_b,
    input  logic                  wr_chk,
    input  logic [REG_ADDR_W-1:0] wr,
    output logic                  match_rd_a,
    output logic                  match_rd_b,
    output logic                  match_wr,
    output logic                  retiring,
    output logic                  valid
);

    sb_entry_t entry;
    logic      live;

    assign valid      = entry.valid;
    assign retiring   = entry.valid && (entry.remaining == MAX_LAT_W'(1));
    // A retiring entry is covered by writeback forwarding, so it never blocks.
    assign live       = entry.valid && !retiring;
    assign match_rd_a = live && rd_a_chk && (entry.dest == rd_a);
    assign match_rd_b = live && rd_b_chk && (entry.dest == rd_b);
    assign match_wr   = live && wr_chk   && (entry.dest == wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
        end else if (flush) begin
            entry <= '0;
        end else if (load) begin
            entry.valid     <= 1'b1;
            entry.dest      <= load_dest;
            entry.remaining <= eff_latency(MAX_LAT_W'(load_lat));
        end else if (entry.valid) begin
            if (retiring) begin
                entry <= '0;
            end else begin
                entry.remaining <= entry.remaining - MAX_LAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uc_scoreboard.sv
// uc_scoreboard: in-flight write scoreboard and issue controller.
//   clk, rst_n   clock, async active-low reset
//   issue        instruction handshake (slave modport): issue_valid, read
//                enables/operands, write_en/dest_c/latency in; issue_ready
//                and hold_registers out (combinational)
//   flush        discard all in-flight entries, block issue this cycle
//   busy         at least one slot occupied
//   stall_count  saturating count of hold cycles (not cleared by flush)
module uc_scoreboard
    import uc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LAT_W = 3,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    uc_scoreboard_if.slave    issue,
    input  logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_count
);

    logic [DEPTH-1:0] match_a, match_b, match_w;
    logic [DEPTH-1:0] retiring, valid;
    logic [DEPTH-1:0] free_slot, alloc_sel, load;
    logic             rd_a_chk, rd_b_chk, wr_chk;
    logic             raw, waw, full, ready, accept;

    // Register 0 never takes part in a hazard or an allocation.
    assign rd_a_chk = issue.read_a_en && (issue.operand_a != REG_ZERO);
    assign rd_b_chk = issue.read_b_en && (issue.operand_b != REG_ZERO);
    assign wr_chk   = issue.write_en  && (issue.dest_c    != REG_ZERO);

    assign raw  = |match_a || |match_b;
    assign waw  = |match_w;
    assign full = (&valid) && !(|retiring);

    assign ready  = !flush && !raw && !waw && !(wr_chk && full);
    assign accept = issue.issue_valid && ready;

    assign issue.issue_ready    = ready;
    assign issue.hold_registers = issue.issue_valid && !ready;

    // Lowest-index slot that is free now or frees up at this edge.
    assign free_slot = ~valid | retiring;

    always_comb begin
        alloc_sel = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (free_slot[i] && (alloc_sel == '0)) begin
                alloc_sel[i] = 1'b1;
            end
        end
    end

    assign load = (accept && wr_chk) ? alloc_sel : '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        uc_sb_slot #(.LAT_W(LAT_W)) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .load       (load[g]),
            .load_dest  (issue.dest_c),
            .load_lat   (issue.latency),
            .rd_a_chk   (rd_a_chk),
            .rd_a       (issue.operand_a),
            .rd_b_chk   (rd_b_chk),
            .rd_b       (issue.operand_b),
            .wr_chk     (wr_chk),
            .wr         (issue.dest_c),
            .match_rd_a (match_a[g]),
            .match_rd_b (match_b[g]),
            .match_wr   (match_w[g]),
            .retiring   (retiring[g]),
            .valid      (valid[g])
        );
    end

    assign busy = |valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (issue.hold_registers && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
